// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared DLX constants: multiply sequencer state encoding and mult funct codes
package dlx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mult_state_t;

    // R-type funct codes that control decode maps onto start/is_signed
    localparam logic [5:0] FN_MULT  = 6'h0E;
    localparam logic [5:0] FN_MULTU = 6'h16;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - decode-side bundle for the multiply sequencer
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             is_signed;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    modport master (
        output start, is_signed, flush, op_a, op_b,
        input  busy, stall, done, prod_hi, prod_lo
    );

    modport slave (
        input  start, is_signed, flush, op_a, op_b,
        output busy, stall, done, prod_hi, prod_lo
    );
endinterface

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - shift-add multiply datapath: operand magnitudes, accumulator, sign fix-up
module mult_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_prod_hi,
    output logic [WIDTH-1:0] o_prod_lo
);
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [WIDTH-1:0]   r_prod_hi;
    logic [WIDTH-1:0]   r_prod_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    // The most negative value negates to itself, which is exactly its unsigned magnitude
    assign w_a_neg    = i_is_signed & i_op_a[WIDTH-1];
    assign w_b_neg    = i_is_signed & i_op_b[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -i_op_a : i_op_a;
    assign w_b_abs    = w_b_neg ? -i_op_b : i_op_b;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_prod     = {r_acc, r_mplier};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= w_a_abs;
                r_mplier <= w_b_abs;
                r_acc    <= '0;
                r_neg    <= w_a_neg ^ w_b_neg;
            end else if (i_step) begin
                // {carry, acc, multiplier} shifted right by one
                r_acc    <= w_sum[WIDTH:1];
                r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
            end
            if (i_fix) begin
                r_prod_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                r_prod_lo <= w_prod_fix[WIDTH-1:0];
            end
        end
    end

    assign o_prod_hi = r_prod_hi;
    assign o_prod_lo = r_prod_lo;
endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - iterative multiply sequencer: FSM, step counter and pipeline stall
module mult_seq_ctrl
    import dlx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_ctrl_if.slave  bus
);
    mult_state_t      r_state;
    mult_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_fix  = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Flush kills the operation before any datapath strobe can land
        if (bus.flush) begin
            w_next = S_IDLE;
            w_load = 1'b0;
            w_step = 1'b0;
            w_fix  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= CNT_W'(WIDTH - 1);
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    mult_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_fix       (w_fix),
        .i_is_signed (bus.is_signed),
        .i_op_a      (bus.op_a),
        .i_op_b      (bus.op_b),
        .o_prod_hi   (bus.prod_hi),
        .o_prod_lo   (bus.prod_lo)
    );

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.stall = w_accept | (r_state == S_RUN) | (r_state == S_FIX);
    assign bus.done  = (r_state == S_DONE);
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - directed-vector bench for mult_seq_ctrl
module tb_mult_seq_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mult_seq_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic s, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start     = s;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
    endtask

    // Called just after a rising edge; returns just after the edge ending the DONE cycle
    task automatic do_mult(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        logic [1:0] sd;
        int         bad;
        set_op(1'b1, sgn, a, b);
        @(negedge clk);
        check({tag, " stall_at_T"}, {63'd0, bus.stall}, 64'd1);
        @(posedge clk);
        #1 set_op(1'b0, 1'b0, 32'd0, 32'd0);
        bad = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            sd = {bus.stall, bus.done};
            if (k < 34 && sd != 2'b10) bad++;
        end
        check({tag, " stall_run_cycles"}, 64'(bad), 64'd0);
        check({tag, " done_at_T34"}, {62'd0, bus.stall, bus.done}, 64'd1);
        check({tag, " product"}, {bus.prod_hi, bus.prod_lo}, exp);
        @(posedge clk);
        #1;
        check({tag, " idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.flush = 1'b0;
        set_op(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {61'd0, bus.busy, bus.stall, bus.done}, 64'd0);
        check("reset_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_mult("multu_3x5",   1'b0, 32'd3,        32'd5,        64'h00000000_0000000F);
        do_mult("mult_m3x5",   1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1);
        do_mult("multu_max",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        do_mult("mult_minsq",  1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        do_mult("mult_0xm1",   1'b1, 32'd0,        32'hFFFFFFFF, 64'd0);
        do_mult("mult_m1xm1",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);

        // start with flush in IDLE: nothing accepted
        set_op(1'b1, 1'b0, 32'd2, 32'd2);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_start_stall", {63'd0, bus.stall}, 64'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        set_op(1'b0, 1'b0, 32'd0, 32'd0);
        check("flush_start_busy", {63'd0, bus.busy}, 64'd0);

        // abort: start at T, ignored start at T+10, flush at T+12
        begin
            int bad;
            set_op(1'b1, 1'b0, 32'd7, 32'd9);
            @(posedge clk);
            bad = 0;
            for (int k = 1; k <= 12; k++) begin
                #1;
                set_op(k == 10, 1'b0, (k == 10) ? 32'd100 : 32'd0, (k == 10) ? 32'd100 : 32'd0);
                bus.flush = (k == 12);
                @(negedge clk);
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
                @(posedge clk);
            end
            #1;
            bus.flush = 1'b0;
            set_op(1'b0, 1'b0, 32'd0, 32'd0);
            check("abort_busy_done_run", 64'(bad), 64'd0);
            check("abort_idle_T13", {62'd0, bus.busy, bus.done}, 64'd0);
            check("abort_prod_kept", {bus.prod_hi, bus.prod_lo}, 64'd1);
        end
        do_mult("restart_7x9", 1'b0, 32'd7, 32'd9, 64'd63);

        // reset mid-RUN
        set_op(1'b1, 1'b0, 32'd7, 32'd9);
        @(posedge clk);
        #1 set_op(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (19) @(posedge clk);
        #1;
        check("run_busy_T20", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrun_reset_ctl", {61'd0, bus.busy, bus.stall, bus.done}, 64'd0);
        check("midrun_reset_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
